// File: rtl/issue_queue.sv
// Dual-issue instruction queue and issue register (pairing enabled by DUAL_ISSUE_EN).
// Latency: a pair accepted at edge E loads the issue register at edge E+1 at the earliest.
// Backpressure: fetch_ready = registered count <= DEPTH-2; ex_stall freezes issue, flush discards all.
module issue_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_valid,
    input  logic [IW-1:0] fetch_instr0,
    input  logic [IW-1:0] fetch_instr1,
    output logic          fetch_ready,
    input  logic          ex_stall,
    input  logic          flush,
    output logic          valid1,
    output logic          valid2,
    output logic [IW-1:0] instr1,
    output logic [IW-1:0] instr2,
    output logic [6:0]    opcode1,
    output logic [6:0]    opcode2,
    output logic          stall
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic [1:0]    pop;
    logic [IW-1:0] head0;
    logic [IW-1:0] head1;

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PW'(1)];

    // Ready looks only at the registered count so fetch never sees a path from ex_stall.
    assign fetch_ready = (count <= CW'(DEPTH - 2));
    assign push        = fetch_valid && fetch_ready;

`ifdef DUAL_ISSUE_EN
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic h_writes;
    logic y_uses_rs2;
    logic raw_hazard;
    logic mem_pair;
    logic split;

    assign h_writes   = (head0[6:0] == OP_LOAD) || (head0[6:0] == OP_REG) || (head0[6:0] == OP_IMM);
    assign y_uses_rs2 = (head1[6:0] == OP_REG) || (head1[6:0] == OP_STORE) || (head1[6:0] == OP_BRANCH);
    assign raw_hazard = h_writes && (head0[11:7] != 5'd0) &&
                        ((head0[11:7] == head1[19:15]) || (y_uses_rs2 && (head0[11:7] == head1[24:20])));
    // Only one memory port, so two memory ops never leave together.
    assign mem_pair   = ((head0[6:0] == OP_LOAD) || (head0[6:0] == OP_STORE)) &&
                        ((head1[6:0] == OP_LOAD) || (head1[6:0] == OP_STORE));
    assign split      = raw_hazard || mem_pair || (head0[6:0] == OP_BRANCH);

    always_comb begin
        pop = 2'd0;
        if (!ex_stall) begin
            if (count == CW'(1)) begin
                pop = 2'd1;
            end else if (count >= CW'(2)) begin
                pop = split ? 2'd1 : 2'd2;
            end
        end
    end
`else
    always_comb begin
        pop = 2'd0;
        if (!ex_stall && (count != '0)) begin
            pop = 2'd1;
        end
    end
`endif

    assign count_nxt = count + (push ? CW'(2) : CW'(0)) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr]          <= fetch_instr0;
            mem[wr_ptr + PW'(1)] <= fetch_instr1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
            instr1 <= '0;
            instr2 <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(2);
            end
            if (!ex_stall) begin
                valid1 <= (pop != 2'd0);
                valid2 <= (pop == 2'd2);
                instr1 <= (pop != 2'd0) ? head0 : '0;
                instr2 <= (pop == 2'd2) ? head1 : '0;
                rd_ptr <= rd_ptr + PW'(pop);
            end
            count <= count_nxt;
        end
    end

    assign opcode1 = instr1[6:0];
    assign opcode2 = instr2[6:0];
    assign stall   = !valid1;

endmodule
